pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline stage register with valid/ready handshake, synchronous flush and a programmable bubble value. It sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), where plain set/reset flops are used today. It adds backpressure and stall support, and an optional two-entry skid mode so that the upstream ready is driven straight from a flop.

## Interface
Parameters:
- DW, 32, payload width in bits (1..256).
- SET_DATA, {DW{1'b0}}, bubble value on out_data_o whenever the stage is empty (e.g. 32'h00000013 NOP on the instruction path).
- SKID, 1, 0 = single-entry stage; 1 = two-entry skid buffer.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous flush; discards all held entries.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage accepts payload this cycle.
- in_data_i  in  DW  upstream payload.
- out_valid_o  out  1  stage holds a valid payload.
- out_ready_i  in  1  downstream accepts payload this cycle.
- out_data_o  out  DW  payload; SET_DATA when out_valid_o=0.
- occ_o  out  2  number of held entries (0..2).

## Operation
- Input transfer: in_valid_i & in_ready_o at a rising edge. Output transfer: out_valid_o & out_ready_i at a rising edge.
- Storage: main register M drives out_data_o. Skid register S exists only when SKID=1.
- States: EMPTY (occ 0), BUSY (occ 1, M valid), FULL (occ 2, M and S valid, SKID=1 only).
- EMPTY: out_valid_o=0, out_data_o=SET_DATA, in_ready_o=1.
  - Input transfer: M<=in_data_i, go to BUSY.
- BUSY, SKID=1: in_ready_o=1.
  - Input and output transfer: M<=in_data_i, stay BUSY.
  - Output transfer only: M<=SET_DATA, go to EMPTY.
  - Input transfer only: S<=in_data_i, go to FULL.
  - Neither: hold.
- FULL: in_ready_o=0.
  - Output transfer: M<=S, S<=SET_DATA, go to BUSY.
  - Otherwise hold.
- SKID=0: in_ready_o = ~out_valid_o | out_ready_i. This is a combinational path from out_ready_i. The state is never FULL.
  - BUSY with input and output transfer: M<=in_data_i.
  - BUSY with output transfer only: go to EMPTY.
- SKID=1: in_ready_o depends only on flops, on rst and on flush_i. There is no path from out_ready_i.
- Ordering: payloads leave in the order they were accepted. None is dropped or duplicated except by flush.
- Flush: M and S are set to SET_DATA and the state goes to EMPTY on the next edge, regardless of handshakes.
  - in_ready_o is forced to 0 while flush_i=1, so no input transfer occurs.
  - An output transfer in the flush cycle still counts downstream. The data on out_data_o that cycle is the held payload.
- Priority: rst > flush_i > handshake updates.

## Timing
- Reset: while rst=1, in_ready_o=0. On the edge, state goes to EMPTY: out_valid_o=0, out_data_o=SET_DATA, occ_o=0.
  - in_ready_o=1 on the first cycle after rst deasserts.
  - Reset mid-operation discards M and S with no partial output.
- Latency: an input transfer at edge N gives out_valid_o=1 with that payload from edge N through the cycle after.
- Throughput: 1 transfer/cycle sustained in both modes when out_ready_i=1.
- Stall: while out_valid_o=1 and out_ready_i=0, out_valid_o and out_data_o hold stable.
- SKID=1 backpressure: after out_ready_i falls, at most one further payload is accepted (into S). in_ready_o drops at the next edge.
- Simultaneous flush_i and rst: reset result. Simultaneous flush_i and in_valid_i: payload not accepted; upstream must re-present it.
- occ_o updates on the same edge as the state.

## Test plan
- Reset and bubble:
  - Stimulus: SET_DATA=32'h13, hold rst=1 for 3 cycles, then release.
  - Required: out_valid_o=0, out_data_o=32'h13 and occ_o=0 throughout. in_ready_o=0 during reset, 1 after.
- Streaming:
  - Stimulus: SKID=1, out_ready_i=1, in_valid_i=1 with data 1,2,3,...,100 on consecutive cycles.
  - Required: outputs 1..100 on consecutive cycles, 1 cycle after each input. occ_o stays 1.
- Backpressure skid:
  - Stimulus: SKID=1, stream A,B,C. Drop out_ready_i after A is presented. Raise it 4 cycles later.
  - Required: A held and stable; B captured in S; occ_o=2; in_ready_o=0 while stalled. Then A, B, C delivered in order with no loss.
- Single-entry mode:
  - Stimulus: SKID=0, out_valid_o=1, out_ready_i=0.
  - Required: in_ready_o=0 combinationally. Raising out_ready_i with in_valid_i=1 replaces M in one edge; occ_o stays 1.
- Flush:
  - Stimulus: SKID=1, FULL with payloads 5 and 6; assert flush_i for 1 cycle with in_valid_i=1 and data 7.
  - Required: in_ready_o=0 in the flush cycle. Next cycle occ_o=0, out_valid_o=0, out_data_o=SET_DATA. 7 is not accepted.
- Reset mid-stall:
  - Stimulus: FULL and stalled, then assert rst for 1 cycle while in_valid_i=1.
  - Required: EMPTY after the edge. No stale payload ever appears on out_data_o with out_valid_o=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake, synchronous flush and bubble value.
// SKID=1 adds a second entry so that in_ready_o comes only from state, not from out_ready_i.
module pipe_stage_reg #(
    parameter int              DW       = 32,
    parameter logic [DW-1:0]   SET_DATA = {DW{1'b0}},
    parameter bit              SKID     = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    occ_o
);

    // Encoding equals the number of held entries, so occ_o is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] m_q, m_d;
    logic [DW-1:0] s_q, s_d;
    logic          out_valid;
    logic          in_xfer;
    logic          out_xfer;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        out_valid = (state_q != EMPTY);
        if (SKID) begin
            in_ready_o = !rst && !flush_i && (state_q != FULL);
        end else begin
            in_ready_o = !rst && !flush_i && (!out_valid || out_ready_i);
        end
        in_xfer  = in_valid_i && in_ready_o;
        out_xfer = out_valid && out_ready_i;

        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;

        if (flush_i) begin
            state_d = EMPTY;
            m_d     = SET_DATA;
            s_d     = SET_DATA;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        m_d     = in_data_i;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        m_d = in_data_i;
                    end else if (out_xfer) begin
                        m_d     = SET_DATA;
                        state_d = EMPTY;
                    end else if (in_xfer && SKID) begin
                        // Downstream stalled: the extra payload parks in S behind M.
                        s_d     = in_data_i;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        m_d     = s_q;
                        s_d     = SET_DATA;
                        state_d = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    m_d     = SET_DATA;
                    s_d     = SET_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: payload registers are reset too, because SET_DATA is architecturally visible on reset.
        if (rst) begin
            state_q <= EMPTY;
            m_q     <= SET_DATA;
            s_q     <= SET_DATA;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    assign out_valid_o = out_valid;
    assign out_data_o  = out_valid ? m_q : SET_DATA;
    assign occ_o       = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: a skid-mode and a single-entry instance share stimulus and are
// compared every cycle against queue-based reference models.
module tb_pipe_stage_reg;

    localparam logic [31:0] SET_A = 32'h0000_0013;
    localparam logic [31:0] SET_B = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        rdy_a, vld_a, rdy_b, vld_b;
    logic [31:0] dat_a, dat_b;
    logic [1:0]  occ_a, occ_b;

    int checks   = 0;
    int failures = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DW(32), .SET_DATA(SET_A), .SKID(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy_a), .in_data_i(in_data),
        .out_valid_o(vld_a), .out_ready_i(out_ready), .out_data_o(dat_a), .occ_o(occ_a)
    );

    pipe_stage_reg #(.DW(32), .SET_DATA(SET_B), .SKID(1'b0)) u_single (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy_b), .in_data_i(in_data),
        .out_valid_o(vld_b), .out_ready_i(out_ready), .out_data_o(dat_b), .occ_o(occ_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare both instances, then advance the models.
    task automatic step(input logic r, input logic f, input logic v,
                        input logic [31:0] d, input logic ordy);
        logic ea_rdy, eb_rdy, ea_vld, eb_vld;
        @(negedge clk);
        rst = r; flush = f; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        ea_vld = (qa.size() > 0);
        eb_vld = (qb.size() > 0);
        ea_rdy = !r && !f && (qa.size() < 2);
        eb_rdy = !r && !f && (!eb_vld || ordy);

        check("skid_in_ready",  {31'b0, rdy_a}, {31'b0, ea_rdy});
        check("skid_out_valid", {31'b0, vld_a}, {31'b0, ea_vld});
        check("skid_out_data",  dat_a, ea_vld ? qa[0] : SET_A);
        check("skid_occ",       {30'b0, occ_a}, qa.size());
        check("single_in_ready",  {31'b0, rdy_b}, {31'b0, eb_rdy});
        check("single_out_valid", {31'b0, vld_b}, {31'b0, eb_vld});
        check("single_out_data",  dat_b, eb_vld ? qb[0] : SET_B);
        check("single_occ",       {30'b0, occ_b}, qb.size());

        if (r || f) begin
            qa.delete();
            qb.delete();
        end else begin
            if (ea_vld && ordy) void'(qa.pop_front());
            if (v && ea_rdy)    qa.push_back(d);
            if (eb_vld && ordy) void'(qb.pop_front());
            if (v && eb_rdy)    qb.push_back(d);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);

        // Reset held for three cycles, then released: bubble value throughout.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'hAAAA_0000 + i, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Streaming 1..100 with downstream always ready.
        for (int i = 1; i <= 100; i++) step(1'b0, 1'b0, 1'b1, i, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Skid backpressure: A accepted, stall as B arrives, C waits 4 cycles.
        step(1'b0, 1'b0, 1'b1, 32'hA, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
        check("skid_full_during_stall", {30'b0, occ_a}, 32'd2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Single-entry replacement while stalled, then released with new input.
        step(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h22, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("single_replaced", dat_b, 32'h22);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush with the skid stage full of 5 and 6 while 7 is offered.
        step(1'b0, 1'b0, 1'b1, 32'h5, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h6, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h7, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset while full and stalled, with input still valid.
        step(1'b0, 1'b0, 1'b1, 32'h8, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h9, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hA5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic including occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom,
                 ($urandom_range(0, 9) < 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
